// File: rtl/stack_sequencer.sv
// Command-level controller for the 8-bit hardware stack: expands each opcode into
// push/pop/tos strobe sequences, runs the stack ALU and guards depth against over/underflow.
module stack_sequencer #(
    parameter int unsigned WORD      = 8,
    parameter int unsigned DEPTH_MAX = 63,
    parameter int unsigned DEPTHW    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [WORD-1:0]   cmd_data,
    output logic              rsp_valid,
    output logic [WORD-1:0]   rsp_data,
    output logic              rsp_err,
    output logic              st_push,
    output logic              st_pop,
    output logic              st_tos,
    output logic [WORD-1:0]   st_din,
    input  logic [WORD-1:0]   st_dout,
    output logic [DEPTHW-1:0] depth,
    output logic              empty,
    output logic              full
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_TOP  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_AND  = 3'd6;
    localparam logic [2:0] OP_NOT  = 3'd7;

    localparam logic [DEPTHW-1:0] DEPTH_FULL = DEPTHW'(DEPTH_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_POPA, S_POPB, S_CAPA, S_CAPB, S_TOSA, S_PUSHR, S_DONE
    } state_t;

    state_t            r_state;
    logic [2:0]        r_op;
    logic [WORD-1:0]   r_a;
    logic [WORD-1:0]   r_b;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [WORD-1:0]   r_rsp_data;
    logic              r_rsp_err;
    logic              r_st_push;
    logic              r_st_pop;
    logic              r_st_tos;
    logic [WORD-1:0]   r_st_din;
    logic [DEPTHW-1:0] r_depth;
    logic              r_empty;
    logic              r_full;

    logic              w_err;
    logic [WORD-1:0]   w_b;
    logic [WORD-1:0]   w_alu;

    // Reject before touching the stack: underflow on too few operands, overflow on PUSH when full.
    always_comb begin
        w_err = 1'b0;
        case (cmd_op)
            OP_POP, OP_TOP, OP_NOT:  w_err = (r_depth == '0);
            OP_ADD, OP_SUB, OP_AND:  w_err = (r_depth < DEPTHW'(2));
            OP_PUSH:                 w_err = (r_depth == DEPTH_FULL);
            default:                 w_err = 1'b0;
        endcase
    end

    // B arrives on st_dout during CAPB; A (old top) was captured one cycle earlier.
    assign w_b = (r_state == S_CAPB) ? st_dout : r_b;

    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_ADD:  w_alu = w_b + r_a;
            OP_SUB:  w_alu = w_b - r_a;
            OP_AND:  w_alu = w_b & r_a;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_NOP;
            r_a         <= '0;
            r_b         <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_st_push   <= 1'b0;
            r_st_pop    <= 1'b0;
            r_st_tos    <= 1'b0;
            r_st_din    <= '0;
            r_depth     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_st_push   <= 1'b0;
            r_st_pop    <= 1'b0;
            r_st_tos    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op        <= cmd_op;
                        r_cmd_ready <= 1'b0;
                        if (w_err) begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                        end else begin
                            case (cmd_op)
                                OP_NOP: begin
                                    r_state     <= S_DONE;
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_err   <= 1'b0;
                                    r_rsp_data  <= '0;
                                end
                                OP_PUSH: begin
                                    r_state   <= S_PUSHR;
                                    r_st_push <= 1'b1;
                                    r_st_din  <= cmd_data;
                                end
                                OP_TOP: begin
                                    r_state  <= S_TOSA;
                                    r_st_tos <= 1'b1;
                                end
                                default: begin
                                    r_state  <= S_POPA;
                                    r_st_pop <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_POPA: begin
                    r_depth <= r_depth - DEPTHW'(1);
                    r_empty <= (r_depth == DEPTHW'(1));
                    r_full  <= 1'b0;
                    if (r_op == OP_POP || r_op == OP_NOT) begin
                        r_state <= S_CAPA;
                    end else begin
                        r_state  <= S_POPB;
                        r_st_pop <= 1'b1;
                    end
                end
                S_POPB: begin
                    r_a     <= st_dout;
                    r_depth <= r_depth - DEPTHW'(1);
                    r_empty <= (r_depth == DEPTHW'(1));
                    r_full  <= 1'b0;
                    r_state <= S_CAPB;
                end
                S_TOSA: begin
                    r_state <= S_CAPA;
                end
                S_CAPA: begin
                    r_a <= st_dout;
                    if (r_op == OP_NOT) begin
                        r_state   <= S_PUSHR;
                        r_st_push <= 1'b1;
                        r_st_din  <= ~st_dout;
                    end else begin
                        r_state     <= S_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= st_dout;
                    end
                end
                S_CAPB: begin
                    r_b       <= st_dout;
                    r_state   <= S_PUSHR;
                    r_st_push <= 1'b1;
                    r_st_din  <= w_alu;
                end
                S_PUSHR: begin
                    r_depth     <= r_depth + DEPTHW'(1);
                    r_empty     <= 1'b0;
                    r_full      <= (r_depth == DEPTH_FULL - DEPTHW'(1));
                    r_state     <= S_DONE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_data  <= r_st_din;
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign st_push   = r_st_push;
    assign st_pop    = r_st_pop;
    assign st_tos    = r_st_tos;
    assign st_din    = r_st_din;
    assign depth     = r_depth;
    assign empty     = r_empty;
    assign full      = r_full;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a behavioural 64-entry stack model attached.
module tb_stack_sequencer;

    localparam int unsigned WORD   = 8;
    localparam int unsigned DEPTHW = 6;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [WORD-1:0]   cmd_data;
    logic              rsp_valid;
    logic [WORD-1:0]   rsp_data;
    logic              rsp_err;
    logic              st_push;
    logic              st_pop;
    logic              st_tos;
    logic [WORD-1:0]   st_din;
    logic [WORD-1:0]   st_dout;
    logic [DEPTHW-1:0] depth;
    logic              empty;
    logic              full;

    int n_checks;
    int n_fail;

    stack_sequencer #(.WORD(WORD), .DEPTH_MAX(63), .DEPTHW(DEPTHW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .st_push   (st_push),
        .st_pop    (st_pop),
        .st_tos    (st_tos),
        .st_din    (st_din),
        .st_dout   (st_dout),
        .depth     (depth),
        .empty     (empty),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack model: pre-increment push, read-then-decrement pop, registered read data.
    logic [WORD-1:0] mem [64];
    logic [5:0]      sp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp      <= '0;
            st_dout <= '0;
        end else if (st_push) begin
            mem[sp + 6'd1] <= st_din;
            sp             <= sp + 6'd1;
        end else if (st_pop) begin
            st_dout <= mem[sp];
            sp      <= sp - 6'd1;
        end else if (st_tos) begin
            st_dout <= mem[sp];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command and check latency, response, strobe timing (bit n = cycle n) and depth.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [7:0] d,
                           input int exp_lat, input logic [7:0] exp_data, input logic exp_err,
                           input logic [15:0] exp_push_m, input logic [15:0] exp_pop_m,
                           input logic [15:0] exp_tos_m, input logic [7:0] exp_din,
                           input int exp_depth);
        logic [15:0] push_m, pop_m, tos_m;
        logic [7:0]  din_seen, got_data;
        logic        got_err;
        int          lat;
        push_m = '0; pop_m = '0; tos_m = '0; din_seen = '0; got_data = '0; got_err = 1'b0; lat = 0;
        @(negedge clk);
        check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd1; cmd_data = 8'hFF;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (st_push) begin push_m[cyc] = 1'b1; din_seen = st_din; end
            if (st_pop)  pop_m[cyc] = 1'b1;
            if (st_tos)  tos_m[cyc] = 1'b1;
            if (rsp_valid) begin
                lat = cyc; got_data = rsp_data; got_err = rsp_err;
                check({tag, ".depth"}, 32'(depth), 32'(exp_depth));
                break;
            end
            @(negedge clk);
        end
        check({tag, ".lat"},  32'(lat),      32'(exp_lat));
        check({tag, ".data"}, 32'(got_data), 32'(exp_data));
        check({tag, ".err"},  32'(got_err),  32'(exp_err));
        check({tag, ".push"}, 32'(push_m),   32'(exp_push_m));
        check({tag, ".pop"},  32'(pop_m),    32'(exp_pop_m));
        check({tag, ".tos"},  32'(tos_m),    32'(exp_tos_m));
        if (exp_push_m != '0) check({tag, ".din"}, 32'(din_seen), 32'(exp_din));
        @(negedge clk);
        check({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int seen_rsp;
        n_checks = 0; n_fail = 0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
        rst = 1'b1;
        #23;
        check("rst.ready", 32'(cmd_ready), 32'd1);
        check("rst.depth", 32'(depth), 32'd0);
        check("rst.empty", 32'(empty), 32'd1);
        check("rst.full",  32'(full),  32'd0);
        check("rst.rsp",   {22'd0, rsp_valid, rsp_err, rsp_data}, 32'd0);
        check("rst.st",    {21'd0, st_push, st_pop, st_tos, st_din}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //            tag        op    data   lat data   err push       pop        tos        din    depth
        run_cmd("push12",   3'd1, 8'h12, 2, 8'h12, 0, 16'b00010, 16'b00000, 16'b00000, 8'h12, 1);
        run_cmd("pop12",    3'd2, 8'h00, 3, 8'h12, 0, 16'b00000, 16'b00010, 16'b00000, 8'h00, 0);
        run_cmd("push05",   3'd1, 8'h05, 2, 8'h05, 0, 16'b00010, 16'b00000, 16'b00000, 8'h05, 1);
        run_cmd("push03",   3'd1, 8'h03, 2, 8'h03, 0, 16'b00010, 16'b00000, 16'b00000, 8'h03, 2);
        run_cmd("sub",      3'd5, 8'h00, 5, 8'h02, 0, 16'b10000, 16'b00110, 16'b00000, 8'h02, 1);
        run_cmd("pop02",    3'd2, 8'h00, 3, 8'h02, 0, 16'b00000, 16'b00010, 16'b00000, 8'h00, 0);
        run_cmd("pushF0",   3'd1, 8'hF0, 2, 8'hF0, 0, 16'b00010, 16'b00000, 16'b00000, 8'hF0, 1);
        run_cmd("push20",   3'd1, 8'h20, 2, 8'h20, 0, 16'b00010, 16'b00000, 16'b00000, 8'h20, 2);
        run_cmd("add",      3'd4, 8'h00, 5, 8'h10, 0, 16'b10000, 16'b00110, 16'b00000, 8'h10, 1);
        run_cmd("not",      3'd7, 8'h00, 4, 8'hEF, 0, 16'b01000, 16'b00010, 16'b00000, 8'hEF, 1);
        run_cmd("top",      3'd3, 8'h00, 3, 8'hEF, 0, 16'b00000, 16'b00000, 16'b00010, 8'h00, 1);
        run_cmd("add_uf",   3'd4, 8'h00, 1, 8'h00, 1, 16'b00000, 16'b00000, 16'b00000, 8'h00, 1);
        run_cmd("nop",      3'd0, 8'h55, 1, 8'h00, 0, 16'b00000, 16'b00000, 16'b00000, 8'h00, 1);
        run_cmd("popEF",    3'd2, 8'h00, 3, 8'hEF, 0, 16'b00000, 16'b00010, 16'b00000, 8'h00, 0);
        run_cmd("pop_uf",   3'd2, 8'h00, 1, 8'h00, 1, 16'b00000, 16'b00000, 16'b00000, 8'h00, 0);
        run_cmd("top_uf",   3'd3, 8'h00, 1, 8'h00, 1, 16'b00000, 16'b00000, 16'b00000, 8'h00, 0);
        run_cmd("push3C",   3'd1, 8'h3C, 2, 8'h3C, 0, 16'b00010, 16'b00000, 16'b00000, 8'h3C, 1);
        run_cmd("pushA5",   3'd1, 8'hA5, 2, 8'hA5, 0, 16'b00010, 16'b00000, 16'b00000, 8'hA5, 2);
        run_cmd("and",      3'd6, 8'h00, 5, 8'h24, 0, 16'b10000, 16'b00110, 16'b00000, 8'h24, 1);
        run_cmd("pop24",    3'd2, 8'h00, 3, 8'h24, 0, 16'b00000, 16'b00010, 16'b00000, 8'h00, 0);

        // Fill to capacity with values 1..63.
        for (int i = 1; i <= 63; i++)
            run_cmd("fill", 3'd1, 8'(i), 2, 8'(i), 0, 16'b10, 16'b0, 16'b0, 8'(i), i);
        check("fill.full",  32'(full),  32'd1);
        check("fill.empty", 32'(empty), 32'd0);
        run_cmd("push_of",  3'd1, 8'hAA, 1, 8'h00, 1, 16'b00000, 16'b00000, 16'b00000, 8'h00, 63);
        check("of.full",    32'(full),  32'd1);
        run_cmd("pop63",    3'd2, 8'h00, 3, 8'h3F, 0, 16'b00000, 16'b00010, 16'b00000, 8'h00, 62);
        check("pop63.full", 32'(full),  32'd0);

        // Reset while the ADD sequence sits in POPB.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mid.popb_strobe", 32'(st_pop), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid.pop",   32'(st_pop),    32'd0);
        check("mid.depth", 32'(depth),     32'd0);
        check("mid.empty", 32'(empty),     32'd1);
        check("mid.ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen_rsp = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen_rsp++;
            @(negedge clk);
        end
        check("mid.no_rsp", 32'(seen_rsp), 32'd0);
        run_cmd("post_push", 3'd1, 8'h77, 2, 8'h77, 0, 16'b00010, 16'b00000, 16'b00000, 8'h77, 1);
        run_cmd("post_pop",  3'd2, 8'h00, 3, 8'h77, 0, 16'b00000, 16'b00010, 16'b00000, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
Command-level controller for the CPU's 8-bit hardware stack (push/pop/tos strobes, registered d_out, pre-increment push, read-then-decrement pop). It accepts one opcode at a time from the multicycle control unit over a valid/ready handshake. It expands each opcode into the correct multi-cycle strobe sequence, performs the stack-ALU operation, and tracks depth so overflow and underflow are rejected before the stack is touched. Every accepted command returns exactly one response pulse.

Parameters:
WORD, 8, data width of stack entries and command/response data
DEPTH_MAX, 63, usable stack entries (entry 0 of a 64-entry stack is never written)
DEPTHW, 6, width of depth counter (must hold DEPTH_MAX)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  high only in IDLE
cmd_op  input  3  0 NOP, 1 PUSH, 2 POP, 3 TOP, 4 ADD, 5 SUB, 6 AND, 7 NOT
cmd_data  input  WORD  immediate for PUSH, ignored otherwise
rsp_valid  output  1  one-cycle completion pulse
rsp_data  output  WORD  result value (see Behaviour)
rsp_err  output  1  qualifies rsp_valid: command rejected
st_push  output  1  stack push strobe
st_pop  output  1  stack pop strobe
st_tos  output  1  stack top-of-stack read strobe
st_din  output  WORD  stack write data
st_dout  input  WORD  stack registered read data, valid the cycle after a pop/tos strobe
depth  output  DEPTHW  current number of entries
empty  output  1  depth==0
full  output  1  depth==DEPTH_MAX

Behaviour:
- Reset (async): state IDLE, depth=0, operand regs A/B=0, rsp_valid=0, rsp_err=0, rsp_data=0, all st_* strobes 0, st_din=0. The stack shares rst, so depth and stack pointer stay aligned. Reset mid-sequence aborts the command with no response.
- FSM states: IDLE, POPA, POPB, CAPA, CAPB, TOSA, PUSHR, DONE. Strobes decode from state only, so at most one st_* is high per cycle.
- Accept occurs when cmd_valid && cmd_ready in IDLE. On accept, latch op and cmd_data, then check:
  - underflow: POP/TOP/NOT with depth<1, or ADD/SUB/AND with depth<2.
  - overflow: PUSH with depth==DEPTH_MAX.
  - On error: go to DONE with rsp_err=1 and rsp_data=0. No strobes fire and depth is unchanged.
- Sequences (cycle 0 = accept cycle), each ending in DONE:
  - NOP: DONE. Response at cycle 1.
  - PUSH: PUSHR (st_push=1, st_din=latched data, depth+1), then DONE. Response at cycle 2, rsp_data=pushed value.
  - POP: POPA (st_pop=1, depth-1), CAPA (A<=st_dout), DONE. Response at cycle 3, rsp_data=A.
  - TOP: TOSA (st_tos=1), CAPA, DONE. Response at cycle 3, depth unchanged.
  - NOT: POPA, CAPA, PUSHR (st_din=~A), DONE. Response at cycle 4, net depth 0.
  - ADD/SUB/AND: POPA, POPB (A<=st_dout, st_pop=1), CAPB (B<=st_dout), PUSHR, DONE. Response at cycle 5, net depth -1.
    - A is the old top, B is the entry below it.
    - ADD: B+A mod 2^WORD. SUB: B-A mod 2^WORD (borrow discarded). AND: B&A.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. rsp_data/rsp_err hold their value until the next DONE.
- depth updates on the strobe cycle. It never wraps: errors pre-empt any out-of-range move.
- cmd_* inputs are ignored outside IDLE. No command queuing.

Test Plan:
- Reset, then PUSH 0x12 -> st_push in cycle 1 with st_din=0x12; rsp_valid cycle 2 with rsp_data=0x12, err=0; depth=1.
- PUSH 0x05, PUSH 0x03, SUB -> two st_pop pulses on consecutive cycles, then st_push with st_din=0x02; rsp cycle 5, data 0x02; depth 1.
- PUSH 0xF0, PUSH 0x20, ADD -> result 0x10 (wrap). Then NOT -> 0xEF. Then TOP -> 0xEF with no pop; depth stays 1.
- POP on empty stack -> rsp_valid at cycle 1 with err=1 and data=0; no st_* strobe; depth 0. ADD with depth 1 -> err=1, depth stays 1.
- 63 PUSHes -> full=1; 64th PUSH -> err=1, no st_push; then POP -> returns the 63rd value, full=0.
- Assert rst during POPB of ADD -> outputs reset immediately, no rsp_valid, depth=0; the next PUSH is accepted normally.
